// File: rtl/cpu_pkg.sv
// Values shared by every pipeline unit (fetch, decode, hazard, debug) so the
// NOP encoding, halt opcode and reset vector are defined in exactly one place.
package cpu_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] PC_RESET    = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds on enable=0 or stall, loads a bubble on flush,
// otherwise captures the fetched instruction and its PC+4.
module if_id_register
    import cpu_pkg::*;
#(
    parameter int B = XLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         stall,
    input  logic         flush,
    input  logic [B-1:0] instr_in,
    input  logic [B-1:0] pc_plus4_in,
    output logic [B-1:0] instruction_D,
    output logic [B-1:0] pc_incrementado_D
);

    logic [B-1:0] instr_d, instr_q;
    logic [B-1:0] pcinc_d, pcinc_q;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default is what infers a latch.
    always_comb begin
        instr_d = instr_q;
        pcinc_d = pcinc_q;
        if (enable && !stall) begin
            if (flush) begin
                instr_d = B'(NOP_INSTR);
                pcinc_d = '0;
            end else begin
                instr_d = instr_in;
                pcinc_d = pc_plus4_in;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= B'(NOP_INSTR);
            pcinc_q <= '0;
        end else begin
            instr_q <= instr_d;
            pcinc_q <= pcinc_d;
        end
    end

    assign instruction_D     = instr_q;
    assign pc_incrementado_D = pcinc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register with redirect/stall/halt handling, instruction
// memory address generation, fetch counter and the IF/ID register.
module instruction_fetch #(
    parameter int          B           = cpu_pkg::XLEN,
    parameter logic [31:0] PC_RESET    = cpu_pkg::PC_RESET,
    parameter logic [5:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         stallF,
    input  logic         stallD,
    input  logic         branch_taken,
    input  logic         jump,
    input  logic [B-1:0] pc_branch,
    input  logic [B-1:0] pc_jump,
    output logic [B-1:0] imem_addr,
    input  logic [B-1:0] imem_data,
    output logic [B-1:0] pc_F,
    output logic [B-1:0] instruction_D,
    output logic [B-1:0] pc_incrementado_D,
    output logic         halted,
    output logic [B-1:0] fetch_count
);

    logic [B-1:0] pc_d, pc_q;
    logic         halted_d, halted_q;
    logic [B-1:0] count_d, count_q;

    logic [B-1:0] pc_plus4;
    logic [B-1:0] target;
    logic         redirect;
    logic         halt_fetched;
    logic         ifid_flush;
    logic         ifid_load;

    assign pc_plus4     = pc_q + B'(4);
    assign redirect     = (jump | branch_taken) & ~stallD;
    assign target       = jump ? pc_jump : pc_branch;
    assign halt_fetched = (imem_data[B-1 -: 6] == HALT_OPCODE);

    // A halted core only ever feeds bubbles; the halt word itself gets in once
    // because halted_q is still low on the edge that sets it.
    assign ifid_flush = redirect | halted_q;
    assign ifid_load  = enable & ~stallD & ~ifid_flush;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (enable && !halted_q) begin
            if (redirect) begin
                pc_d = target;
            end else if (!stallF) begin
                if (halt_fetched) halted_d = 1'b1;
                else              pc_d     = pc_plus4;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (ifid_load) count_d = count_q + B'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= B'(PC_RESET);
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    if_id_register #(.B(B)) u_if_id (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .stall             (stallD),
        .flush             (ifid_flush),
        .instr_in          (imem_data),
        .pc_plus4_in       (pc_plus4),
        .instruction_D     (instruction_D),
        .pc_incrementado_D (pc_incrementado_D)
    );

    assign imem_addr   = pc_q;
    assign pc_F        = pc_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small word-addressed memory model
// feeds imem_data, and every expected value below is hand-computed.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        stallF, stallD;
    logic        branch_taken, jump;
    logic [31:0] pc_branch, pc_jump;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] pc_F, instruction_D, pc_incrementado_D, fetch_count;
    logic        halted;

    logic [31:0] mem [256];
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[9:2]];

    instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .stallF            (stallF),
        .stallD            (stallD),
        .branch_taken      (branch_taken),
        .jump              (jump),
        .pc_branch         (pc_branch),
        .pc_jump           (pc_jump),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .pc_F              (pc_F),
        .instruction_D     (instruction_D),
        .pc_incrementado_D (pc_incrementado_D),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                               input logic [31:0] e_inc, input logic [31:0] e_cnt, input logic e_halt);
        check({tag, ".pc_F"}, pc_F, e_pc);
        check({tag, ".instr"}, instruction_D, e_ins);
        check({tag, ".pcinc"}, pc_incrementado_D, e_inc);
        check({tag, ".count"}, fetch_count, e_cnt);
        check({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halt});
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | i;
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0007;
        reset = 1'b1;
        enable = 1'b1;
        {stallF, stallD, branch_taken, jump} = '0;
        pc_branch = '0;
        pc_jump = '0;
        #12;
        check_state("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch
        step(); check_state("seq1", 32'h4, 32'h2001_0005, 32'h4, 32'd1, 1'b0);
        step(); check_state("seq2", 32'h8, 32'h2002_0007, 32'h8, 32'd2, 1'b0);
        step(); check_state("seq3", 32'hC, 32'h2000_0002, 32'hC, 32'd3, 1'b0);
        step(); check_state("seq4", 32'h10, 32'h2000_0003, 32'h10, 32'd4, 1'b0);
        check("seq4.imem_addr", imem_addr, 32'h10);

        // Jump from pc 8
        do_reset();
        step(); step();
        check("pre_jump.pc_F", pc_F, 32'h8);
        jump = 1'b1; pc_jump = 32'h40;
        step(); check_state("jump", 32'h40, 32'h0, 32'h0, 32'd2, 1'b0);
        jump = 1'b0;
        step(); check_state("after_jump", 32'h44, 32'h2000_0010, 32'h44, 32'd3, 1'b0);

        // Jump beats branch; then branch alone
        jump = 1'b1; pc_jump = 32'h100; branch_taken = 1'b1; pc_branch = 32'h200;
        step(); check_state("prio", 32'h100, 32'h0, 32'h0, 32'd3, 1'b0);
        jump = 1'b0;
        step(); check_state("branch", 32'h200, 32'h0, 32'h0, 32'd3, 1'b0);
        branch_taken = 1'b0;
        step(); check_state("after_branch", 32'h204, 32'h2000_0080, 32'h204, 32'd4, 1'b0);

        // Redirect suppressed by stallD
        jump = 1'b1; branch_taken = 1'b1; stallF = 1'b1; stallD = 1'b1;
        step(); check_state("redir_stalled", 32'h204, 32'h2000_0080, 32'h204, 32'd4, 1'b0);
        branch_taken = 1'b0; stallF = 1'b0; stallD = 1'b0; pc_jump = 32'h10;
        step(); check("to10.pc_F", pc_F, 32'h10);
        jump = 1'b0;

        // Full stall for three cycles
        stallF = 1'b1; stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_state("stall", 32'h10, 32'h0, 32'h0, 32'd4, 1'b0);
        end
        stallF = 1'b0; stallD = 1'b0;
        step(); check_state("release", 32'h14, 32'h2000_0004, 32'h14, 32'd5, 1'b0);

        // stallF only: IF/ID recaptures the same word and still counts
        stallF = 1'b1;
        step(); check_state("stallF1", 32'h14, 32'h2000_0005, 32'h18, 32'd6, 1'b0);
        step(); check_state("stallF2", 32'h14, 32'h2000_0005, 32'h18, 32'd7, 1'b0);
        stallF = 1'b0;

        // PC+4 wrap
        jump = 1'b1; pc_jump = 32'hFFFF_FFFC;
        step(); check("wrap_pre.pc_F", pc_F, 32'hFFFF_FFFC);
        jump = 1'b0;
        step(); check_state("wrap", 32'h0, 32'h2000_00FF, 32'h0, 32'd8, 1'b0);

        // enable=0 freezes everything, even with a redirect pending
        enable = 1'b0; jump = 1'b1; pc_jump = 32'h40;
        step(); check_state("disabled", 32'h0, 32'h2000_00FF, 32'h0, 32'd8, 1'b0);
        enable = 1'b1; jump = 1'b0;

        // Halt at 0x0C
        mem[3] = 32'hFC00_0000;
        do_reset();
        check_state("rst2", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step(); step(); step();
        check("pre_halt.pc_F", pc_F, 32'hC);
        step(); check_state("halt", 32'hC, 32'hFC00_0000, 32'h10, 32'd4, 1'b1);
        step(); check_state("halted1", 32'hC, 32'h0, 32'h0, 32'd4, 1'b1);
        jump = 1'b1; pc_jump = 32'h80;
        step(); check_state("halted_jump", 32'hC, 32'h0, 32'h0, 32'd4, 1'b1);
        jump = 1'b0;

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1 check_state("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Redirect in the same cycle the halt word is fetched wins
        step(); step(); step();
        check("pre_halt2.pc_F", pc_F, 32'hC);
        jump = 1'b1; pc_jump = 32'h40;
        step(); check_state("halt_squash", 32'h40, 32'h0, 32'h0, 32'd3, 1'b0);
        jump = 1'b0;
        step(); check_state("after_squash", 32'h44, 32'h2000_0010, 32'h44, 32'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end pipeline stage directly upstream of instruction decode.
- Holds the program counter and selects the next PC from sequential, branch-target and jump-target sources.
- Presents a byte address to the instruction memory and registers the returned word plus PC+4 into the IF/ID pipeline register consumed by decode.
- Handles stall, flush-on-redirect, single-step enable and a sticky halt for the debug unit.

Parameters:
- B, 32, width of PC, instruction and data words.
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode (bits 31:26) that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = pipeline may advance this cycle (debug step/run); 0 = hold all state.
- stallF  in  1  hazard unit: hold PC.
- stallD  in  1  hazard unit: hold IF/ID register.
- branch_taken  in  1  decode resolved a taken branch.
- jump  in  1  decode holds a jump (j/jal/jr/jalr).
- pc_branch  in  B  branch target from decode.
- pc_jump  in  B  jump target from decode.
- imem_addr  out  B  byte address to instruction memory (combinational read).
- imem_data  in  B  instruction word at imem_addr, same cycle.
- pc_F  out  B  current PC.
- instruction_D  out  B  IF/ID instruction to decode.
- pc_incrementado_D  out  B  IF/ID PC+4 to decode.
- halted  out  1  sticky halt flag.
- fetch_count  out  B  number of non-bubble instructions loaded into IF/ID.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-halt):
  - pc_F = PC_RESET; instruction_D = 0 (NOP); pc_incrementado_D = 0; halted = 0; fetch_count = 0.
- Combinational outputs:
  - imem_addr = pc_F.
  - pc_plus4 = pc_F + 4, modulo 2^B; 32'hFFFF_FFFC wraps to 0.
- Redirect:
  - redirect = (jump | branch_taken) & ~stallD.
  - Target priority: jump (pc_jump) over branch_taken (pc_branch) when both are high.
- PC register update, on each rising edge, first matching rule wins:
  1. enable = 0 -> hold.
  2. halted = 1 -> hold.
  3. redirect -> load target. Redirect overrides stallF.
  4. stallF = 1 -> hold.
  5. Fetched opcode == HALT_OPCODE -> hold PC; set halted = 1.
  6. Otherwise -> load pc_plus4.
- IF/ID register update, on each rising edge, first matching rule wins:
  1. enable = 0 -> hold.
  2. stallD = 1 -> hold.
  3. redirect or halted = 1 -> load bubble (instruction_D = 0, pc_incrementado_D = 0). There are no delay slots.
  4. Otherwise -> instruction_D = imem_data; pc_incrementado_D = pc_plus4.
- Halt:
  - The halt instruction itself passes into IF/ID exactly once (it arrives via rule 4 in the cycle halted is set).
  - From then on IF/ID receives bubbles.
  - halted clears only on reset.
  - A redirect arriving in the same cycle the halt word is fetched wins: PC loads the target, halted stays 0, the halt word is squashed.
- fetch_count:
  - Increments by 1 (wrapping at 2^B) exactly on edges where IF/ID takes rule 4.
  - Unchanged on hold or bubble.
- Latency: an instruction at address A appears on instruction_D one edge after pc_F = A with no stall; the redirect penalty is one bubble.
- stallF = 1 with stallD = 0 is legal: IF/ID rule 4 re-captures the same word each cycle; fetch_count still counts each load.

Decomposition:
- Shared package cpu_pkg holds NOP_INSTR = 32'h0, HALT_OPCODE and PC_RESET, so decode, hazard and debug units use the same values.
- One natural sub-module: if_id_register. It takes enable, stall and flush and carries instruction_D and pc_incrementado_D.
- PC register, next-PC selection, halt flag and counter live in instruction_fetch.

Test Plan:
- Reset, then 4 cycles, enable = 1, memory holds 0x20010005 at 0 and 0x20020007 at 4:
  - pc_F sequence 0, 4, 8, 12.
  - instruction_D = 0x20010005 after edge 1, 0x20020007 after edge 2.
  - fetch_count = 4 after 4 edges.
- pc_F = 8, jump = 1, pc_jump = 0x40:
  - next pc_F = 0x40; instruction_D = 0; fetch_count unchanged on that edge.
- Same cycle: jump = 1 (pc_jump = 0x100), branch_taken = 1 (pc_branch = 0x200):
  - pc_F = 0x100.
- Same cycle: jump = 1, branch_taken = 1, stallD = 1:
  - redirect ignored; PC and IF/ID hold.
- stallF = 1, stallD = 1 for 3 cycles at pc_F = 0x10:
  - pc_F, instruction_D and fetch_count all frozen.
  - Release: pc_F = 0x14 next edge.
- HALT word 0xFC000000 at 0x0C:
  - instruction_D = 0xFC000000 once; halted = 1; pc_F stays 0x0C.
  - Later IF/ID loads bubbles.
  - Assert reset mid-cycle: halted = 0 and pc_F = 0 immediately, without waiting for a clock edge.
